// File: rtl/conv_w_pkg.sv
// ============================================================================
// Module      : conv_w_pkg
// Description : Shared definitions for the convolution weight loader: FSM
//               state encoding, default layer geometry (shared with the
//               multiply-adder array) and small sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_w_pkg;

    // Default geometry, also used by the multiply-adder array.
    localparam int DEF_WEIGHT_W   = 8;
    localparam int DEF_KERNEL_NUM = 4;
    localparam int DEF_KERNEL_LEN = 32;
    localparam int DEF_ROM_AW     = 8;

    // Loader FSM states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Number of weights held by one bank.
    function automatic int total_weights(input int kernel_num, input int kernel_len);
        return kernel_num * kernel_len;
    endfunction

    // Index width for a counter over n entries (never zero bits wide).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/weight_bank.sv
// ============================================================================
// Module      : weight_bank
// Description : KERNEL_NUM x KERNEL_LEN weight register file.
//               One write port addressed by (kernel, tap); one combinational
//               column-read port returning tap rt_i of every kernel, kernel 0
//               in the LSBs.
// Ports       : clk, we_i/wk_i/wt_i/wdata_i (write), rt_i -> col_o (read)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_bank
    import conv_w_pkg::*;
#(
    parameter int WEIGHT_W   = DEF_WEIGHT_W,
    parameter int KERNEL_NUM = DEF_KERNEL_NUM,
    parameter int KERNEL_LEN = DEF_KERNEL_LEN,
    parameter int KW         = idx_w(KERNEL_NUM),
    parameter int TW         = idx_w(KERNEL_LEN)
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [KW-1:0]                  wk_i,
    input  logic [TW-1:0]                  wt_i,
    input  logic [WEIGHT_W-1:0]            wdata_i,
    input  logic [TW-1:0]                  rt_i,
    output logic [WEIGHT_W*KERNEL_NUM-1:0] col_o
);

    // Contents need no reset: every entry is written before it is read.
    logic [WEIGHT_W-1:0] mem_q [KERNEL_NUM][KERNEL_LEN];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wk_i][wt_i] <= wdata_i;
        end
    end

    genvar k;
    generate
        for (k = 0; k < KERNEL_NUM; k++) begin : g_col
            assign col_o[k*WEIGHT_W +: WEIGHT_W] = mem_q[k][rt_i];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/conv_weight_loader.sv
// ============================================================================
// Module      : conv_weight_loader
// Description : Loads one layer's kernel weights from a synchronous weight ROM
//               into a register bank, then streams them KERNEL_NUM weights per
//               beat (one beat per tap) under valid/ready back-pressure.
//               A loaded bank can be replayed without touching the ROM.
// Ports       : clk, rst_n (async, active low)
//               start_i, replay_i, base_addr_i        - control
//               rom_en_o, rom_addr_o, rom_dout_i      - weight ROM
//               w_valid_o, w_ready_i, w_data_o, w_last_o - weight stream
//               busy_o, done_o                        - status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_weight_loader
    import conv_w_pkg::*;
#(
    parameter int WEIGHT_W   = DEF_WEIGHT_W,
    parameter int KERNEL_NUM = DEF_KERNEL_NUM,
    parameter int KERNEL_LEN = DEF_KERNEL_LEN,
    parameter int ROM_AW     = DEF_ROM_AW
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           replay_i,
    input  logic [ROM_AW-1:0]              base_addr_i,
    output logic                           rom_en_o,
    output logic [ROM_AW-1:0]              rom_addr_o,
    input  logic [WEIGHT_W-1:0]            rom_dout_i,
    output logic                           w_valid_o,
    input  logic                           w_ready_i,
    output logic [WEIGHT_W*KERNEL_NUM-1:0] w_data_o,
    output logic                           w_last_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int KW = idx_w(KERNEL_NUM);
    localparam int TW = idx_w(KERNEL_LEN);
    localparam int DW = WEIGHT_W * KERNEL_NUM;

    localparam logic [KW-1:0] C_LAST_K = KW'(KERNEL_NUM - 1);
    localparam logic [TW-1:0] C_LAST_T = TW'(KERNEL_LEN - 1);

    state_e              state_q,    state_d;
    logic                rom_en_q,   rom_en_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [KW-1:0]       ld_k_q,     ld_k_d;     // kernel index of issued read
    logic [TW-1:0]       ld_t_q,     ld_t_d;     // tap index of issued read
    logic                rd_vld_q,   rd_vld_d;   // ROM data valid this cycle
    logic [KW-1:0]       wr_k_q,     wr_k_d;     // destination of that data
    logic [TW-1:0]       wr_t_q,     wr_t_d;
    logic [TW-1:0]       t_q,        t_d;        // tap currently presented
    logic                w_valid_q,  w_valid_d;
    logic [DW-1:0]       w_data_q,   w_data_d;
    logic                w_last_q,   w_last_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                loaded_q,   loaded_d;

    logic [TW-1:0]       rd_tap;
    logic [DW-1:0]       bank_col;
    logic [DW-1:0]       col_fwd;

    // Tap to be presented next: 0 when entering STREAM, t+1 while streaming.
    assign rd_tap = (state_q == ST_STREAM && t_q != C_LAST_T) ? (t_q + TW'(1)) : '0;

    weight_bank #(
        .WEIGHT_W   (WEIGHT_W),
        .KERNEL_NUM (KERNEL_NUM),
        .KERNEL_LEN (KERNEL_LEN),
        .KW         (KW),
        .TW         (TW)
    ) u_bank (
        .clk     (clk),
        .we_i    (rd_vld_q),
        .wk_i    (wr_k_q),
        .wt_i    (wr_t_q),
        .wdata_i (rom_dout_i),
        .rt_i    (rd_tap),
        .col_o   (bank_col)
    );

    // The last ROM word is written on the same edge that captures the first
    // beat (DRAIN -> STREAM); forward it when it lands in the column read.
    always_comb begin
        col_fwd = bank_col;
        if (rd_vld_q && wr_t_q == rd_tap) begin
            col_fwd[int'(wr_k_q)*WEIGHT_W +: WEIGHT_W] = rom_dout_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_en_d   = rom_en_q;
        rom_addr_d = rom_addr_q;
        ld_k_d     = ld_k_q;
        ld_t_d     = ld_t_q;
        rd_vld_d   = rom_en_q;
        wr_k_d     = ld_k_q;
        wr_t_d     = ld_t_q;
        t_d        = t_q;
        w_valid_d  = w_valid_q;
        w_data_d   = w_data_q;
        w_last_d   = w_last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        loaded_d   = loaded_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_LOAD;
                    rom_en_d   = 1'b1;
                    rom_addr_d = base_addr_i;
                    ld_k_d     = '0;
                    ld_t_d     = '0;
                    busy_d     = 1'b1;
                end else if (replay_i && loaded_q) begin
                    state_d   = ST_STREAM;
                    t_d       = '0;
                    w_valid_d = 1'b1;
                    w_data_d  = col_fwd;
                    w_last_d  = (rd_tap == C_LAST_T);
                    busy_d    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ld_k_q == C_LAST_K && ld_t_q == C_LAST_T) begin
                    state_d  = ST_DRAIN;
                    rom_en_d = 1'b0;
                end else begin
                    // Address wraps naturally at ROM_AW bits.
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                    if (ld_t_q == C_LAST_T) begin
                        ld_t_d = '0;
                        ld_k_d = ld_k_q + KW'(1);
                    end else begin
                        ld_t_d = ld_t_q + TW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                state_d   = ST_STREAM;
                loaded_d  = 1'b1;
                t_d       = '0;
                w_valid_d = 1'b1;
                w_data_d  = col_fwd;
                w_last_d  = (rd_tap == C_LAST_T);
            end
            ST_STREAM: begin
                if (w_valid_q && w_ready_i) begin
                    if (t_q == C_LAST_T) begin
                        state_d   = ST_DONE;
                        t_d       = '0;
                        w_valid_d = 1'b0;
                        w_last_d  = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        t_d      = t_q + TW'(1);
                        w_data_d = col_fwd;
                        w_last_d = (rd_tap == C_LAST_T);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            ld_k_q     <= '0;
            ld_t_q     <= '0;
            rd_vld_q   <= 1'b0;
            wr_k_q     <= '0;
            wr_t_q     <= '0;
            t_q        <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            ld_k_q     <= ld_k_d;
            ld_t_q     <= ld_t_d;
            rd_vld_q   <= rd_vld_d;
            wr_k_q     <= wr_k_d;
            wr_t_q     <= wr_t_d;
            t_q        <= t_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_last_q   <= w_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            loaded_q   <= loaded_d;
        end
    end

    assign rom_en_o   = rom_en_q;
    assign rom_addr_o = rom_addr_q;
    assign w_valid_o  = w_valid_q;
    assign w_data_o   = w_data_q;
    assign w_last_o   = w_last_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_weight_loader.sv
// ============================================================================
// Module      : tb_conv_weight_loader
// Description : Self-checking bench for conv_weight_loader with default
//               geometry. ROM word at address a holds a.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_conv_weight_loader;

    localparam int WW    = 8;
    localparam int KN    = 4;
    localparam int KL    = 32;
    localparam int AW    = 8;
    localparam int TOTAL = KN * KL;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start_i = 1'b0;
    logic           replay_i = 1'b0;
    logic [AW-1:0]  base_addr_i = '0;
    logic           rom_en_o;
    logic [AW-1:0]  rom_addr_o;
    logic [WW-1:0]  rom_dout_i;
    logic           w_valid_o;
    logic           w_ready_i = 1'b1;
    logic [WW*KN-1:0] w_data_o;
    logic           w_last_o;
    logic           busy_o;
    logic           done_o;

    conv_weight_loader #(
        .WEIGHT_W   (WW),
        .KERNEL_NUM (KN),
        .KERNEL_LEN (KL),
        .ROM_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .replay_i    (replay_i),
        .base_addr_i (base_addr_i),
        .rom_en_o    (rom_en_o),
        .rom_addr_o  (rom_addr_o),
        .rom_dout_i  (rom_dout_i),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready_i),
        .w_data_o    (w_data_o),
        .w_last_o    (w_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word at address a is a, one cycle after rom_en.
    always @(posedge clk) begin
        if (rom_en_o) rom_dout_i <= rom_addr_o;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [WW*KN-1:0] exp_beat(input logic [AW-1:0] base, input int t);
        logic [WW*KN-1:0] r;
        for (int k = 0; k < KN; k++) r[k*WW +: WW] = 8'(base + 8'(k*KL + t));
        return r;
    endfunction

    // Results of the last run
    int n_rom, first_rom, addr_err, first_valid, nb, last_cyc, done_cyc, stall_err;
    logic busy_after, done_after;
    logic [WW*KN-1:0] beats [64];
    logic             lasts [64];

    task automatic run(input bit use_start, input logic [AW-1:0] base, input bit rnd, input bit glitch);
        logic prev_stall, prev_last;
        logic [WW*KN-1:0] prev_data;
        n_rom = 0; first_rom = -1; addr_err = 0; first_valid = -1; nb = 0;
        last_cyc = -1; done_cyc = -1; stall_err = 0; busy_after = 1'bx; done_after = 1'bx;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        @(negedge clk);
        if (use_start) start_i = 1'b1; else replay_i = 1'b1;
        base_addr_i = base;
        w_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; replay_i = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            start_i     = glitch && (c == 5 || c == TOTAL + 5);
            base_addr_i = start_i ? 8'h55 : base;
            w_ready_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rom_en_o) begin
                if (first_rom < 0) first_rom = c;
                if (rom_addr_o != 8'(base + 8'(n_rom))) addr_err++;
                n_rom++;
            end
            if (w_valid_o && first_valid < 0) first_valid = c;
            if (prev_stall && (!w_valid_o || w_data_o != prev_data || w_last_o != prev_last))
                stall_err++;
            prev_stall = w_valid_o && !w_ready_i;
            prev_data  = w_data_o;
            prev_last  = w_last_o;
            if (w_valid_o && w_ready_i) begin
                if (nb < 64) begin
                    beats[nb] = w_data_o;
                    lasts[nb] = w_last_o;
                end
                nb++;
                if (w_last_o) last_cyc = c;
            end
            if (done_o) begin
                done_cyc = c;
                @(negedge clk);
                busy_after = busy_o;
                done_after = done_o;
                break;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        w_ready_i = 1'b1;
        chk("run_terminated", 64'(done_cyc >= 0), 64'd1);
    endtask

    task automatic chk_beats(input string name, input logic [AW-1:0] base);
        int errs = 0;
        for (int t = 0; t < KL; t++)
            if (beats[t] !== exp_beat(base, t) || lasts[t] !== (t == KL - 1)) errs++;
        chk(name, 64'(errs), 64'd0);
    endtask

    typedef struct {
        logic [AW-1:0]    base;
        int               tap;
        logic [WW*KN-1:0] data;
        logic             last;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int cur_base;
        int hs;

        tbl[0] = '{8'h00,  0, 32'h6040_2000, 1'b0};
        tbl[1] = '{8'h00,  5, 32'h6545_2505, 1'b0};
        tbl[2] = '{8'h00, 31, 32'h7F5F_3F1F, 1'b1};
        tbl[3] = '{8'hF0,  0, 32'h5030_10F0, 1'b0};
        tbl[4] = '{8'hF0, 15, 32'h5F3F_1FFF, 1'b0};
        tbl[5] = '{8'hF0, 16, 32'h6040_2000, 1'b0};
        tbl[6] = '{8'h80,  0, 32'hE0C0_A080, 1'b0};
        tbl[7] = '{8'h13, 31, 32'h9272_5232, 1'b1};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {rom_en_o, rom_addr_o, w_valid_o, w_data_o, w_last_o, busy_o, done_o}, 64'd0);
        rst_n = 1'b1;

        // Replay before any load is refused
        @(negedge clk); replay_i = 1'b1;
        @(negedge clk); replay_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("replay_unloaded_busy", {busy_o, w_valid_o, rom_en_o}, 64'd0);

        // Table-driven beat checks
        cur_base = -1;
        for (int i = 0; i < 8; i++) begin
            if (int'(tbl[i].base) != cur_base) begin
                run(1'b1, tbl[i].base, 1'b0, 1'b0);
                cur_base = int'(tbl[i].base);
                if (tbl[i].base == 8'h00) begin
                    chk("rom_reads", 64'(n_rom), 64'(TOTAL));
                    chk("first_rom_cycle", 64'(first_rom), 64'd1);
                    chk("rom_addr_seq", 64'(addr_err), 64'd0);
                    chk("first_valid_cycle", 64'(first_valid), 64'd130);
                    chk("beat_count", 64'(nb), 64'd32);
                    chk("last_cycle", 64'(last_cyc), 64'd161);
                    chk("done_cycle", 64'(done_cyc), 64'd162);
                    chk("after_done_busy_done", {busy_after, done_after}, 64'd0);
                end
                if (tbl[i].base == 8'hF0) chk("wrap_addr_seq", 64'(addr_err), 64'd0);
            end
            chk($sformatf("vec%0d_data", i), 64'(beats[tbl[i].tap]), 64'(tbl[i].data));
            chk($sformatf("vec%0d_last", i), 64'(lasts[tbl[i].tap]), 64'(tbl[i].last));
        end

        // Replay of the bank loaded from 0x13
        run(1'b0, 8'h00, 1'b0, 1'b0);
        chk("replay_first_valid", 64'(first_valid), 64'd1);
        chk("replay_no_rom", 64'(n_rom), 64'd0);
        chk("replay_done_cycle", 64'(done_cyc), 64'd33);
        chk_beats("replay_beats", 8'h13);

        // Random back-pressure
        run(1'b1, 8'h00, 1'b1, 1'b0);
        chk("rnd_beat_count", 64'(nb), 64'd32);
        chk("rnd_stall_stable", 64'(stall_err), 64'd0);
        chk_beats("rnd_beats", 8'h00);

        // start pulsed during LOAD and STREAM has no effect
        run(1'b1, 8'h40, 1'b0, 1'b1);
        chk("glitch_addr_seq", 64'(addr_err), 64'd0);
        chk("glitch_rom_reads", 64'(n_rom), 64'(TOTAL));
        chk("glitch_beat_count", 64'(nb), 64'd32);
        chk("glitch_done_cycle", 64'(done_cyc), 64'd162);
        chk_beats("glitch_beats", 8'h40);

        // Reset while beat 10 is presented
        @(negedge clk); replay_i = 1'b1;
        @(negedge clk); replay_i = 1'b0;
        hs = 0;
        for (int c = 0; c < 100; c++) begin
            w_ready_i = 1'b1;
            if (w_valid_o && hs == 10) break;
            if (w_valid_o && w_ready_i) hs++;
            @(negedge clk);
        end
        chk("beat10_reached", 64'(hs), 64'd10);
        chk("beat10_data", 64'(w_data_o), 64'(exp_beat(8'h40, 10)));
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {rom_en_o, rom_addr_o, w_valid_o, w_data_o, w_last_o, busy_o, done_o}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); replay_i = 1'b1;
        @(negedge clk); replay_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("replay_after_reset_refused", {busy_o, w_valid_o}, 64'd0);
        run(1'b1, 8'h80, 1'b0, 1'b0);
        chk("reload_beat0", 64'(beats[0]), 64'hE0C0_A080);
        chk_beats("reload_beats", 8'h80);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
